seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the tile's `uo_out[6:0]` segment bus. It holds one hex nibble per digit, scans `NUM_DIGITS` common-anode/cathode-agnostic digit selects with a programmable dwell and an anti-ghosting guard gap, and pulses once per completed frame. It supersedes the single-digit, fixed-pattern segment output of earlier tiles and sits between the tile's control logic and the top-level output pins.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 115 +++++++++++
 tb/tb_seg7_scan_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: scan FSM states, segment bit positions and the hex-to-segment table
// shared by the seven-segment display driver.
package seg7_pkg;

   typedef enum logic [1:0] {S_IDLE, S_GUARD, S_DRIVE} state_e;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Entry n is the a..g pattern for hex digit n (bit0 = a).
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to a..g segment pattern lookup.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex display scanner with per-slot guard gap and frame tick.
// Define SEG7_DP_EN to add the dp_mask input and registered dp_out decimal-point output.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 1000,
   parameter int GUARD      = 2,
   localparam int IDX_W     = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [3:0]            wr_val,
   input  logic [NUM_DIGITS-1:0] blank_mask,
   output logic [6:0]            seg_out,
   output logic [NUM_DIGITS-1:0] dig_sel,
   output logic                  frame_tick
`ifdef SEG7_DP_EN
  ,input  logic [NUM_DIGITS-1:0] dp_mask,
   output logic                  dp_out
`endif
);

   localparam int PCNT_W = $clog2(PRESCALE);

   state_e            state_q, state_d;
   logic [PCNT_W-1:0] pcnt_q, pcnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              wrap_q, wrap_d;
   logic [3:0]        regs_q [NUM_DIGITS];
   logic [6:0]        dec_seg;
   logic              drive;
   logic              last_idx;

   seg7_decode u_decode (
      .nib_i (regs_q[idx_q]),
      .seg_o (dec_seg)
   );

   assign drive    = state_q == S_DRIVE;
   assign last_idx = idx_q == IDX_W'(NUM_DIGITS - 1);

   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      if (!ena) begin
         state_d = S_IDLE;
         pcnt_d  = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_GUARD;
               pcnt_d  = '0;
               idx_d   = '0;
            end
            S_GUARD: begin
               pcnt_d  = pcnt_q + 1'b1;
               state_d = pcnt_q == PCNT_W'(GUARD - 1) ? S_DRIVE : S_GUARD;
            end
            S_DRIVE: begin
               if (pcnt_q == PCNT_W'(PRESCALE - 1)) begin
                  pcnt_d  = '0;
                  idx_d   = last_idx ? '0 : idx_q + 1'b1;
                  wrap_d  = last_idx;
                  state_d = S_GUARD;
               end else begin
                  pcnt_d = pcnt_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs follow the registered state one cycle later; wrap_q delays the
   // frame pulse so it lines up with the first dark cycle of digit 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_GUARD;
         pcnt_q     <= '0;
         idx_q      <= '0;
         wrap_q     <= 1'b0;
         regs_q     <= '{default: 4'h0};
         seg_out    <= '0;
         dig_sel    <= '0;
         frame_tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcnt_q     <= pcnt_d;
         idx_q      <= idx_d;
         wrap_q     <= wrap_d;
         seg_out    <= drive && !blank_mask[idx_q] ? dec_seg : '0;
         dig_sel    <= drive ? NUM_DIGITS'(1) << idx_q : '0;
         frame_tick <= wrap_q;
         if (wr_en && int'(wr_idx) < NUM_DIGITS)
            regs_q[wr_idx] <= wr_val;
      end
   end

`ifdef SEG7_DP_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         dp_out <= 1'b0;
      else
         dp_out <= drive && dp_mask[idx_q];
   end
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: table, directed and random checks of the display scanner
// against a position-counting reference model (NUM_DIGITS=4, PRESCALE=8, GUARD=2).
module tb_seg7_scan_driver;

   localparam int N = 4;
   localparam int P = 8;
   localparam int G = 2;

   typedef struct {
      logic [3:0] nib;
      logic [6:0] seg;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_idx = '0;
   logic [3:0] wr_val = '0;
   logic [3:0] blank_mask = '0;
   logic [6:0] seg_out;
   logic [3:0] dig_sel;
   logic       frame_tick;

   logic       ena6 = 1'b1;
   logic       wr_en6 = 1'b0;
   logic [2:0] wr_idx6 = '0;
   logic [3:0] wr_val6 = '0;
   logic [6:0] seg6;
   logic [5:0] sel6;
   logic       tick6;

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int ps = -1;
   logic [3:0] mregs [N] = '{default: 4'h0};
   logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   vec_t tbl [16];

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .GUARD(G)) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_idx(wr_idx),
      .wr_val(wr_val), .blank_mask(blank_mask), .seg_out(seg_out),
      .dig_sel(dig_sel), .frame_tick(frame_tick)
   );

   seg7_scan_driver #(.NUM_DIGITS(6), .PRESCALE(P), .GUARD(G)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .ena(ena6), .wr_en(wr_en6), .wr_idx(wr_idx6),
      .wr_val(wr_val6), .blank_mask(6'b0), .seg_out(seg6),
      .dig_sel(sel6), .frame_tick(tick6)
   );

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // One clock: compare against the model, then advance the model with the
   // inputs this edge sampled (callers change inputs only between steps).
   task automatic step();
      logic [6:0] es;
      logic [3:0] ed;
      logic       et;
      int         d;
      @(posedge clk);
      #1;
      cyc++;
      es = '0;
      ed = '0;
      et = 1'b0;
      if (!rst_n) begin
         ps = 0;
         mregs = '{default: 4'h0};
      end else begin
         if (ps >= 0 && ps % P >= G) begin
            d  = (ps / P) % N;
            ed = 4'(1 << d);
            es = blank_mask[d] ? 7'h00 : lut[mregs[d]];
         end
         et = ps >= N * P && ps % (N * P) == 0;
         ps = !ena ? -1 : (ps < 0 ? 0 : ps + 1);
         if (wr_en) mregs[wr_idx] = wr_val;
      end
      chk("model_seg", seg_out, es);
      chk("model_sel", dig_sel, ed);
      chk("model_tick", frame_tick, et);
   endtask

   task automatic wr(input logic [1:0] i, input logic [3:0] v);
      wr_en = 1'b1; wr_idx = i; wr_val = v;
      step();
      wr_en = 1'b0;
   endtask

   task automatic wait_sel(input logic [3:0] t);
      int n = 0;
      while (dig_sel != t && n < 64) begin step(); n++; end
      if (dig_sel != t) chk("wait_sel_timeout", dig_sel, t);
   endtask

   task automatic wait_tick(output int at);
      int n = 0;
      step();
      while (!frame_tick && n < 40) begin step(); n++; end
      if (!frame_tick) chk("wait_tick_timeout", 0, 1);
      at = cyc;
   endtask

   initial begin
      int t1, t2, n_sel, n_bad, n_tick;
      logic [6:0] cap [N];
      logic [6:0] cap6 [6];

      tbl = '{'{4'h1, 7'h06}, '{4'h8, 7'h7F}, '{4'hA, 7'h77}, '{4'hF, 7'h71},
              '{4'h0, 7'h3F}, '{4'h2, 7'h5B}, '{4'h3, 7'h4F}, '{4'h4, 7'h66},
              '{4'h5, 7'h6D}, '{4'h6, 7'h7D}, '{4'h7, 7'h07}, '{4'h9, 7'h6F},
              '{4'hB, 7'h7C}, '{4'hC, 7'h39}, '{4'hD, 7'h5E}, '{4'hE, 7'h79}};

      // Reset, then scan with no writes.
      ena = 1'b1;
      step();
      step();
      chk("reset_seg", seg_out, 0);
      chk("reset_sel", dig_sel, 0);
      chk("reset_tick", frame_tick, 0);
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step();
         chk("start_sel", dig_sel, c <= 2 ? 0 : 1);
         chk("start_seg", seg_out, c <= 2 ? 0 : 'h3F);
      end
      wait_tick(t1);
      wait_tick(t2);
      chk("tick_period", t2 - t1, N * P);

      // Table-driven decode: four digits per frame.
      for (int g = 0; g < 4; g++) begin
         for (int d = 0; d < N; d++) wr(2'(d), tbl[4 * g + d].nib);
         cap = '{default: 7'h00};
         for (int c = 0; c < 40; c++) begin
            step();
            for (int d = 0; d < N; d++)
               if (dig_sel == 4'(1 << d)) cap[d] = seg_out;
         end
         for (int d = 0; d < N; d++) chk("table_seg", cap[d], tbl[4 * g + d].seg);
      end

      // Blanking digit 2 keeps its slot dark but selected.
      blank_mask = 4'b0100;
      n_sel = 0; n_bad = 0; n_tick = 0;
      for (int c = 0; c < N * P; c++) begin
         step();
         if (dig_sel == 4'b0100) begin
            n_sel++;
            if (seg_out != 0) n_bad++;
         end
         if (frame_tick) n_tick++;
      end
      chk("blank_slot_cycles", n_sel, P - G);
      chk("blank_dark", n_bad, 0);
      chk("blank_frame_ticks", n_tick, 1);
      blank_mask = 4'b0000;

      // Drop ena in the middle of digit 1, then restart.
      wait_sel(4'b0010);
      step();
      step();
      ena = 1'b0;
      step();
      for (int c = 0; c < 4; c++) begin
         step();
         chk("off_sel", dig_sel, 0);
         chk("off_seg", seg_out, 0);
      end
      ena = 1'b1;
      step();
      for (int c = 1; c <= 3; c++) begin
         step();
         chk("restart_sel", dig_sel, c < 3 ? 0 : 1);
         chk("restart_tick", frame_tick, 0);
      end

      // Reset mid-slot clears the digit registers.
      wait_sel(4'b0100);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_sel = 0; n_bad = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (dig_sel != 0) begin
            n_sel++;
            if (seg_out != 'h3F) n_bad++;
         end
      end
      chk("rst_cleared_bad", n_bad, 0);
      chk("rst_driven_cycles", n_sel > 0, 1);

      // Six-digit instance: edge index 5 accepted, index 7 ignored.
      for (int d = 0; d < 6; d++) begin
         wr_en6 = 1'b1; wr_idx6 = 3'(d); wr_val6 = 4'(d + 1);
         step();
      end
      wr_idx6 = 3'd5; wr_val6 = 4'hE;
      step();
      wr_idx6 = 3'd7; wr_val6 = 4'h0;
      step();
      wr_en6 = 1'b0;
      cap6 = '{default: 7'h00};
      for (int c = 0; c < 56; c++) begin
         step();
         for (int d = 0; d < 6; d++)
            if (sel6 == 6'(1 << d)) cap6[d] = seg6;
      end
      for (int d = 0; d < 6; d++) chk("oob_digit", cap6[d], d == 5 ? lut[14] : lut[d + 1]);

      // Random traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         rst_n = $urandom_range(0, 499) != 0;
         wr_en = $urandom_range(0, 3) == 0;
         wr_idx = 2'($urandom);
         wr_val = 4'($urandom);
         if ($urandom_range(0, 31) == 0) blank_mask = 4'($urandom);
         if ($urandom_range(0, 99) == 0) ena = ~ena;
         step();
      end
      rst_n = 1'b1;
      wr_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1);
   end

endmodule
